div_check_sched: RTL and testbench
==================================

Name: div_check_sched

Overview:
- Scheduler and shared bit-serial modulo engine for divisibility checks.
- Up to NREQ requesters each submit a W-bit word plus a modulus.
- Round-robin arbitration grants one job at a time.
- The block shifts the word MSB-first through a residue recurrence, one bit per cycle, then returns the remainder and a divisible flag tagged with the requester ID.
- Sits between client blocks and the single shared residue datapath, so the datapath is never replicated per client.

Parameters:
- NREQ, 4: number of requesters (2..8).
- W, 8: data word width in bits (1..32).
- MODW, 4: modulus width; legal modulus 1..2^MODW-1.
- IDW, $clog2(NREQ): requester ID width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_data  in  NREQ*W  packed words; requester i at [i*W +: W].
- req_mod  in  NREQ*MODW  packed moduli; requester i at [i*MODW +: MODW].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  IDW  requester that owns the result.
- rsp_rem  out  MODW  remainder, data mod modulus.
- rsp_div  out  1  1 when rsp_rem==0 and modulus is legal.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset is clk and resetn: synchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_rem=0, rsp_div=0, busy=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
  - On the handshake (req_valid & req_ready), latch the word, modulus and ID; set residue r=0 and bit counter=W; go to SHIFT.
  - req_ready is 0 in all other states.
- SHIFT:
  - Each cycle, r_next = 2r + bit, where bit is the current MSB of the shift register.
  - If r_next >= M, subtract M once. Use MODW+1-bit intermediate; r < M is invariant, so one subtract suffices.
  - Shift the register left; decrement the counter. After W cycles go to DONE.
- DONE:
  - rsp_valid=1; rsp_rem=r; rsp_div=(r==0); rsp_id=latched ID.
  - All outputs are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready: go to IDLE and set rr_ptr = grant+1 (wraps to 0 past NREQ-1).
- Latency: handshake in cycle T gives rsp_valid first high in cycle T+W+1.
- Back-to-back: a new grant can occur no earlier than the cycle after the response handshake, so throughput is one job per W+2 cycles.
- Modulus 1: every word gives rem=0, div=1.
- Modulus 0 is illegal: SHIFT still runs W cycles, no subtraction occurs, and the result is rem=0, div=0.
- Requester drops req_valid before being granted: no effect, no error.
- req_data and req_mod are sampled only on the handshake cycle.
- Reset mid-SHIFT or mid-DONE: the job is discarded, no response is issued, and rr_ptr returns to 0.

Optional Feature:
- Macro: DIV_CHECK_SCHED_ERR_EN.
- When defined:
  - Extra port rsp_err, out, 1, reset value 0.
  - Modulus 0 skips SHIFT: IDLE goes directly to DONE, so rsp_valid appears at T+1 with rsp_err=1, rsp_rem=0, rsp_div=0.
  - rsp_err=0 for every legal modulus.
- When undefined: no rsp_err port, and modulus 0 follows the W-cycle path described above.

Test Plan:
- Single job: requester 0 submits data 8'd25, mod 5; handshake at T -> rsp_valid at T+9 with rsp_id=0, rsp_rem=0, rsp_div=1.
- Non-divisible: requester 1 submits data 8'd26, mod 7 -> rsp_rem=5, rsp_div=0, rsp_id=1.
- Round-robin: all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0, with each grant W+2=10 cycles apart.
- Backpressure: rsp_ready=0 for 3 cycles in DONE -> rsp_valid and payload stable; req_ready stays all-zero; release completes the handshake.
- Edge moduli:
  - data 8'hFF, mod 1 -> rem 0, div 1.
  - data 8'hFF, mod 15 -> rem 0, div 1.
  - data 8'd0, mod 0 -> rem 0, div 0; with DIV_CHECK_SCHED_ERR_EN, rsp_err=1 at T+1.
- Reset mid-SHIFT: assert resetn=0 on cycle T+4 -> no response; busy=0, req_ready=0; the next grant goes to requester 0.

Source files
------------

// File: rtl/div_check_sched.sv
// rtl/div_check_sched.sv - round-robin scheduler over one shared bit-serial residue engine
// Optional: DIV_CHECK_SCHED_ERR_EN adds rsp_err and a fast path for modulus 0.
module div_check_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int MODW = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_data,
    input  logic [NREQ*MODW-1:0] req_mod,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [MODW-1:0]      rsp_rem,
    output logic                 rsp_div,
`ifdef DIV_CHECK_SCHED_ERR_EN
    output logic                 rsp_err,
`endif
    output logic                 busy
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_id;
    logic [W-1:0]    r_sreg;
    logic [MODW-1:0] r_mod;
    logic [MODW-1:0] r_res;
    logic [CW-1:0]   r_cnt;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [MODW-1:0] r_rsp_rem;
    logic            r_rsp_div;
    logic            r_busy;
`ifdef DIV_CHECK_SCHED_ERR_EN
    logic            r_rsp_err;
`endif

    logic            w_gnt_found;
    logic [IDW-1:0]  w_gnt_id;
    logic [IDW:0]    w_idx;
    logic [NREQ-1:0] w_onehot;
    logic [W-1:0]    w_gnt_data;
    logic [MODW-1:0] w_gnt_mod;
    logic [MODW:0]   w_r2;
    logic [MODW:0]   w_mod_ext;
    logic [MODW:0]   w_r_sub;
    logic [MODW-1:0] w_r_next;
    logic [MODW-1:0] w_rem_final;
    logic [IDW-1:0]  w_ptr_next;

    // Search starts at the round-robin pointer and wraps modulo NREQ.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        w_idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (!w_gnt_found && req_valid[w_idx[IDW-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = w_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        if (r_state == S_IDLE && resetn && w_gnt_found) begin
            w_onehot[w_gnt_id] = 1'b1;
        end
    end

    assign req_ready  = w_onehot;
    assign w_gnt_data = req_data[int'(w_gnt_id)*W +: W];
    assign w_gnt_mod  = req_mod[int'(w_gnt_id)*MODW +: MODW];

    // Residue stays below M, so 2r+bit < 2M and a single subtract restores it.
    assign w_r2        = {r_res, r_sreg[W-1]};
    assign w_mod_ext   = {1'b0, r_mod};
    assign w_r_sub     = w_r2 - w_mod_ext;
    assign w_r_next    = ((r_mod != '0) && (w_r2 >= w_mod_ext)) ? w_r_sub[MODW-1:0] : w_r2[MODW-1:0];
    assign w_rem_final = (r_mod == '0) ? '0 : w_r_next;
    assign w_ptr_next  = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_sreg      <= '0;
            r_mod       <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_rem   <= '0;
            r_rsp_div   <= 1'b0;
            r_busy      <= 1'b0;
`ifdef DIV_CHECK_SCHED_ERR_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_found) begin
                        r_id   <= w_gnt_id;
                        r_sreg <= w_gnt_data;
                        r_mod  <= w_gnt_mod;
                        r_res  <= '0;
                        r_cnt  <= CW'(W);
                        r_busy <= 1'b1;
`ifdef DIV_CHECK_SCHED_ERR_EN
                        if (w_gnt_mod == '0) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_id    <= w_gnt_id;
                            r_rsp_rem   <= '0;
                            r_rsp_div   <= 1'b0;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                        end
`else
                        r_state <= S_SHIFT;
`endif
                    end
                end
                S_SHIFT: begin
                    r_res  <= w_r_next;
                    r_sreg <= r_sreg << 1;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_rem   <= w_rem_final;
                        r_rsp_div   <= (r_mod != '0) && (w_r_next == '0);
`ifdef DIV_CHECK_SCHED_ERR_EN
                        r_rsp_err   <= 1'b0;
`endif
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_rr_ptr    <= w_ptr_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_rem   = r_rsp_rem;
    assign rsp_div   = r_rsp_div;
    assign busy      = r_busy;
`ifdef DIV_CHECK_SCHED_ERR_EN
    assign rsp_err   = r_rsp_err;
`endif

endmodule

// File: tb/tb_div_check_sched.sv
// tb/tb_div_check_sched.sv - directed self-checking bench for div_check_sched
module tb_div_check_sched;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [15:0] req_mod;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_rem;
    logic        rsp_div;
    logic        busy;
`ifdef DIV_CHECK_SCHED_ERR_EN
    logic        rsp_err;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    div_check_sched #(.NREQ(4), .W(8), .MODW(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_mod   (req_mod),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_rem   (rsp_rem),
        .rsp_div   (rsp_div),
`ifdef DIV_CHECK_SCHED_ERR_EN
        .rsp_err   (rsp_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic do_job(input string tag, input int idx, input logic [7:0] d, input logic [3:0] m,
                          input logic [3:0] erem, input logic ediv, input int elat, input int bp);
        int n;
        req_valid = 4'b0001 << idx;
        req_data[idx*8 +: 8] = d;
        req_mod[idx*4 +: 4]  = m;
        rsp_ready = (bp == 0);
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(4'b0001 << idx));
        @(posedge clk); #1;
        req_valid = '0;
        req_data  = ~req_data;
        req_mod   = ~req_mod;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".lat"}, n, elat);
        chk({tag, ".id"}, 32'(rsp_id), idx);
        chk({tag, ".rem"}, 32'(rsp_rem), 32'(erem));
        chk({tag, ".div"}, 32'(rsp_div), 32'(ediv));
`ifdef DIV_CHECK_SCHED_ERR_EN
        chk({tag, ".err"}, 32'(rsp_err), 32'(m == 4'd0));
`endif
        if (bp > 0) begin
            req_valid = 4'hF;
            repeat (bp) begin
                @(posedge clk); #1;
                chk({tag, ".bp_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, ".bp_rem"}, 32'(rsp_rem), 32'(erem));
                chk({tag, ".bp_id"}, 32'(rsp_id), idx);
                chk({tag, ".bp_ready"}, 32'(req_ready), 32'd0);
            end
            req_valid = '0;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, ".rsp_clr"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        int prev;
        int got;
        int seen;
        resetn    = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'h1234_5678;
        req_mod   = 16'h3333;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.id", 32'(rsp_id), 32'd0);
        chk("rst.rem", 32'(rsp_rem), 32'd0);
        chk("rst.div", 32'(rsp_div), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        resetn    = 1'b1;
        @(posedge clk); #1;

        do_job("j25m5",  0, 8'd25,  4'd5,  4'd0, 1'b1, 8, 0);
        do_job("j26m7",  1, 8'd26,  4'd7,  4'd5, 1'b0, 8, 0);
        do_job("jabm13", 2, 8'hAB,  4'd13, 4'd2, 1'b0, 8, 3);
        do_job("jffm1",  3, 8'hFF,  4'd1,  4'd0, 1'b1, 8, 0);
        do_job("jffm15", 0, 8'hFF,  4'd15, 4'd0, 1'b1, 8, 0);
`ifdef DIV_CHECK_SCHED_ERR_EN
        do_job("j0m0",   1, 8'd0,   4'd0,  4'd0, 1'b0, 0, 0);
`else
        do_job("j0m0",   1, 8'd0,   4'd0,  4'd0, 1'b0, 8, 0);
`endif

        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = 8'(21 + i);
            req_mod[i*4 +: 4]  = 4'd5;
        end
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        prev = 0;
        #1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (req_ready == 4'b0 && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
            got = oh_idx(req_ready);
            chk("rr.id", got, k % 4);
            if (k > 0) chk("rr.gap", cyc - prev, 10);
            prev = cyc;
            @(posedge clk); #1;
        end
        req_valid = '0;
        n = 0;
        while (busy && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rr.drain", 32'(busy), 32'd0);

        do_job("j200m3", 2, 8'd200, 4'd3, 4'd2, 1'b0, 8, 0);
        req_valid = 4'b1000;
        req_data[24 +: 8] = 8'd99;
        req_mod[12 +: 4]  = 4'd7;
        #1;
        chk("mid.ready", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn    = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("mid.ready_in_rst", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.valid", 32'(rsp_valid), 32'd0);
        chk("mid.ready_after", 32'(req_ready), 32'd0);
        req_valid = '0;
        resetn    = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("mid.no_rsp", seen, 0);
        req_valid = 4'hF;
        #1;
        chk("mid.next_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
